// File: rtl/out_block_collector_if.sv
// -----------------------------------------------------------------------------
// out_block_collector_if
// Groups the handshake and memory-write signals of out_block_collector.
//   start    : one-cycle pulse that begins a new result matrix
//   in_valid : a result block is present on in_data
//   in_ready : the collector takes the block when in_valid && in_ready
//   in_data  : N x N block, element (r,c) at [WIDTH*(r*N+c) +: WIDTH]
//   out_we   : write strobe to the row-major output memory
//   out_addr : row-major word address
//   out_data : one block-row segment, element c at [WIDTH*c +: WIDTH]
//   done     : level, the full matrix has been written
// Modports: slave = collector side, master = producer / memory side.
// -----------------------------------------------------------------------------
interface out_block_collector_if #(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 2,
  parameter int ADDR_WIDTH = 8
);
  logic                                   start;
  logic                                   in_valid;
  logic                                   in_ready;
  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] in_data;
  logic                                   out_we;
  logic [ADDR_WIDTH-1:0]                  out_addr;
  logic [WIDTH*BLOCK_SIZE-1:0]            out_data;
  logic                                   done;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, out_we, out_addr, out_data, done
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, out_we, out_addr, out_data, done
  );
endinterface

// File: rtl/out_block_collector.sv
// -----------------------------------------------------------------------------
// out_block_collector
// Takes N x N result blocks from a systolic array, one at a time, and writes
// them into a row-major output memory one block row per cycle. Blocks arrive
// column-fastest across a ROW_SIZE_MAT_C x COL_SIZE_MAT_C grid of blocks; once
// the last block is written the collector parks in DONE with done high until
// the next start.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (overrides start)
//   bus  : out_block_collector_if.slave (start, in_valid/in_ready/in_data,
//          out_we/out_addr/out_data, done)
// Optional feature: define OUT_COLLECTOR_RELU_EN to zero every negative
// element on its way to memory; without it elements pass unchanged.
// -----------------------------------------------------------------------------
module out_block_collector #(
  parameter int WIDTH          = 16,
  parameter int BLOCK_SIZE     = 2,
  parameter int ROW_SIZE_MAT_C = 8,
  parameter int COL_SIZE_MAT_C = 8,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  out_block_collector_if.slave bus
);

  localparam int SEG_W = WIDTH * BLOCK_SIZE;
  localparam int ROW_W = (ROW_SIZE_MAT_C > 1) ? $clog2(ROW_SIZE_MAT_C) : 1;
  localparam int COL_W = (COL_SIZE_MAT_C > 1) ? $clog2(COL_SIZE_MAT_C) : 1;
  localparam int R_W   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                                 state_q;
  logic [ROW_W-1:0]                       blk_row_q;
  logic [COL_W-1:0]                       blk_col_q;
  logic [R_W-1:0]                         r_q;
  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] block_q;
  logic                                   out_we_q;
  logic [ADDR_WIDTH-1:0]                  out_addr_q;
  logic [SEG_W-1:0]                       out_data_q;
  logic                                   done_q;

  logic [R_W-1:0]   r_d;
  logic             last_row;
  logic             last_blk;
  logic             in_ready;
  logic [SEG_W-1:0] blk_seg [BLOCK_SIZE];

  // Optional ReLU applied to one block-row segment.
  function automatic logic [SEG_W-1:0] shape(input logic [SEG_W-1:0] seg);
    logic [SEG_W-1:0] res;
    res = seg;
`ifdef OUT_COLLECTOR_RELU_EN
    for (int c = 0; c < BLOCK_SIZE; c++) begin
      if (seg[WIDTH*c + WIDTH-1]) res[WIDTH*c +: WIDTH] = '0;
    end
`endif
    return res;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ROW_W-1:0] br,
    input logic [COL_W-1:0] bc,
    input logic [R_W-1:0]   rr
  );
    return ADDR_WIDTH'((32'(br) * 32'(BLOCK_SIZE) + 32'(rr))
                       * 32'(COL_SIZE_MAT_C) + 32'(bc));
  endfunction

  // Shaped rows of the latched block, indexed by block row.
  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_row
      assign blk_seg[gi] = shape(block_q[SEG_W*gi +: SEG_W]);
    end
  endgenerate

  assign r_d      = r_q + R_W'(1);
  assign last_row = (r_q == R_W'(BLOCK_SIZE - 1));
  assign last_blk = (blk_row_q == ROW_W'(ROW_SIZE_MAT_C - 1)) &&
                    (blk_col_q == COL_W'(COL_SIZE_MAT_C - 1));

  // start must be seen combinationally so that a colliding block is refused.
  assign in_ready = (state_q == IDLE) && !bus.start && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      blk_row_q  <= '0;
      blk_col_q  <= '0;
      r_q        <= '0;
      block_q    <= '0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else if (bus.start) begin
      // Abandon whatever is in flight; address/data hold their last value.
      state_q   <= IDLE;
      blk_row_q <= '0;
      blk_col_q <= '0;
      r_q       <= '0;
      out_we_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_we_q <= 1'b0;
          if (bus.in_valid && in_ready) begin
            // Row 0 goes out straight from the input so the first write
            // lands the cycle after the accept.
            block_q    <= bus.in_data;
            r_q        <= '0;
            out_we_q   <= 1'b1;
            out_addr_q <= word_addr(blk_row_q, blk_col_q, '0);
            out_data_q <= shape(bus.in_data[SEG_W-1:0]);
            state_q    <= WRITE;
          end
        end
        WRITE: begin
          // r_q is the row being written during this cycle.
          if (!last_row) begin
            r_q        <= r_d;
            out_we_q   <= 1'b1;
            out_addr_q <= word_addr(blk_row_q, blk_col_q, r_d);
            out_data_q <= blk_seg[r_d];
          end else begin
            r_q      <= '0;
            out_we_q <= 1'b0;
            if (last_blk) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              if (blk_col_q == COL_W'(COL_SIZE_MAT_C - 1)) begin
                blk_col_q <= '0;
                blk_row_q <= blk_row_q + ROW_W'(1);
              end else begin
                blk_col_q <= blk_col_q + COL_W'(1);
              end
            end
          end
        end
        DONE: begin
          out_we_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          out_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.out_we   = out_we_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_data = out_data_q;
  assign bus.done     = done_q;

endmodule
